// File: rtl/machine_pkg.sv
// Shared definitions for the nibble lane of the 16-bit machine datapath.
//   NIB_W      : nibble width (4)
//   WORD_W     : machine word width (16)
//   SLOTS      : nibbles per word (4); a slot index is therefore 2 bits
//   slot_t     : 2-bit slot index type
//   slot_shamt : maps a slot index to its bit offset within the word (0/4/8/12)
package machine_pkg;

  localparam int NIB_W  = 4;
  localparam int WORD_W = 16;
  localparam int SLOTS  = 4;

  typedef logic [1:0] slot_t;

  // Slot k occupies bits [4k+3:4k]; the offset is simply the slot index times 4.
  function automatic logic [3:0] slot_shamt(input slot_t slot);
    return {slot, 2'b00};
  endfunction

endpackage

// File: rtl/machine_nib_insert.sv
// Combinational nibble insertion into a word accumulator.
// Ports:
//   acc      in   WORD_W  current accumulator contents
//   nib      in   NIB_W   nibble to insert
//   slot     in   2       physical slot receiving the nibble
//   acc_next out  WORD_W  acc with nib OR-ed in at bit offset slot*4
//   mask_bit out  SLOTS   one-hot flag for the written slot
module machine_nib_insert
  import machine_pkg::*;
(
  input  logic [WORD_W-1:0] acc,
  input  logic [NIB_W-1:0]  nib,
  input  slot_t             slot,
  output logic [WORD_W-1:0] acc_next,
  output logic [SLOTS-1:0]  mask_bit
);

  // Pure insertion: the nibble is zero-extended before shifting, so no
  // sign bits ever spill into higher slots.
  always_comb begin
    acc_next = acc | (WORD_W'(nib) << slot_shamt(slot));
    mask_bit = SLOTS'(1) << slot;
  end

endmodule

// File: rtl/machine_nibble_pack.sv
// Packs a stream of 4-bit nibbles into 16-bit words with valid/ready on both
// sides and a single output word register.
// Parameters:
//   MSN_FIRST  0: first nibble of a word lands in slot 0 (bits 3:0)
//              1: first nibble of a word lands in slot 3 (bits 15:12)
// Ports:
//   system1000       in   1   clock, rising edge
//   system1000_rstn  in   1   asynchronous active-low reset
//   in_valid         in   1   in_nib is valid
//   in_ready         out  1   packer accepts in_nib this cycle
//   in_nib           in   4   nibble data
//   in_last          in   1   close the current word after this nibble
//   out_valid        out  1   out_word is valid
//   out_ready        in   1   consumer accepts out_word
//   out_word         out  16  packed word; unfilled slots are 0
//   out_mask         out  4   bit k set means slot k was written
//   out_partial      out  1   word closed by in_last before all slots filled
module machine_nibble_pack
  import machine_pkg::*;
#(
  parameter int MSN_FIRST = 0
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIB_W-1:0]  in_nib,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [SLOTS-1:0]  out_mask,
  output logic              out_partial
);

  slot_t             ds;        // count of nibbles already in the accumulator
  logic [WORD_W-1:0] acc;
  logic [SLOTS-1:0]  acc_mask;

  slot_t             slot;
  logic [WORD_W-1:0] acc_next;
  logic [SLOTS-1:0]  mask_bit;
  logic              accept;
  logic              complete;

  // Ready whenever the output register is empty or being drained this cycle,
  // so back-to-back words flow without a bubble (combinational out_ready path).
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((ds == 2'd3) || in_last);

  // Stream order ds maps to a physical slot; MSN_FIRST mirrors the order.
  assign slot = (MSN_FIRST != 0) ? slot_t'(2'd3 - ds) : ds;

  machine_nib_insert u_insert (
    .acc      (acc),
    .nib      (in_nib),
    .slot     (slot),
    .acc_next (acc_next),
    .mask_bit (mask_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      ds          <= '0;
      acc         <= '0;
      acc_mask    <= '0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      out_mask    <= '0;
      out_partial <= 1'b0;
    end else if (complete) begin
      // Completion may coincide with a drain; the new word simply replaces
      // the old one and out_valid stays high.
      out_word    <= acc_next;
      out_mask    <= acc_mask | mask_bit;
      out_partial <= (ds != 2'd3);
      out_valid   <= 1'b1;
      ds          <= '0;
      acc         <= '0;
      acc_mask    <= '0;
    end else begin
      if (accept) begin
        ds       <= ds + 2'd1;
        acc      <= acc_next;
        acc_mask <= acc_mask | mask_bit;
      end
      // Drained with nothing new: data registers hold their last value.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_machine_nibble_pack.sv
// Self-checking bench for machine_nibble_pack. Two instances (MSN_FIRST=0 and
// MSN_FIRST=1) share one input stream; a word-level reference model built
// from a queue of accepted nibbles predicts both.
module tb_machine_nibble_pack;

  logic        system1000;
  logic        system1000_rstn;
  logic        in_valid;
  logic [3:0]  in_nib;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_partial0;
  logic [15:0] out_word0;
  logic [3:0]  out_mask0;
  logic        in_ready1, out_valid1, out_partial1;
  logic [15:0] out_word1;
  logic [3:0]  out_mask1;

  int n_cmp;
  int n_fail;

  // Reference model state
  int q[$];        // nibbles accepted into the current word, in stream order
  bit mv;          // output word pending
  bit mp;          // partial flag of last word
  int mw0, mm0;    // last word / mask, MSN_FIRST=0
  int mw1, mm1;    // last word / mask, MSN_FIRST=1
  int words;

  machine_nibble_pack #(.MSN_FIRST(0)) u0 (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .in_valid        (in_valid),
    .in_ready        (in_ready0),
    .in_nib          (in_nib),
    .in_last         (in_last),
    .out_valid       (out_valid0),
    .out_ready       (out_ready),
    .out_word        (out_word0),
    .out_mask        (out_mask0),
    .out_partial     (out_partial0)
  );

  machine_nibble_pack #(.MSN_FIRST(1)) u1 (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .in_valid        (in_valid),
    .in_ready        (in_ready1),
    .in_nib          (in_nib),
    .in_last         (in_last),
    .out_valid       (out_valid1),
    .out_ready       (out_ready),
    .out_word        (out_word1),
    .out_mask        (out_mask1),
    .out_partial     (out_partial1)
  );

  initial system1000 = 1'b0;
  always #5 system1000 = ~system1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mv  = 1'b0;
    mp  = 1'b0;
    mw0 = 0; mm0 = 0;
    mw1 = 0; mm1 = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid0"},   32'(out_valid0),   32'(mv));
    check({tag, "_valid1"},   32'(out_valid1),   32'(mv));
    check({tag, "_word0"},    32'(out_word0),    mw0);
    check({tag, "_word1"},    32'(out_word1),    mw1);
    check({tag, "_mask0"},    32'(out_mask0),    mm0);
    check({tag, "_mask1"},    32'(out_mask1),    mm1);
    check({tag, "_partial0"}, 32'(out_partial0), 32'(mp));
    check({tag, "_partial1"}, 32'(out_partial1), 32'(mp));
  endtask

  // One clock cycle: drive inputs, check readiness, clock, update model, check.
  task automatic step(input logic v, input logic [3:0] n, input logic l, input logic r);
    bit rdy;
    bit comp;
    in_valid  = v;
    in_nib    = n;
    in_last   = l;
    out_ready = r;
    #1;
    rdy = !mv || r;
    check("in_ready0", 32'(in_ready0), 32'(rdy));
    check("in_ready1", 32'(in_ready1), 32'(rdy));
    @(posedge system1000);
    #1;
    comp = 1'b0;
    if (v && rdy) begin
      q.push_back(int'(n));
      if (q.size() == 4 || l) begin
        mw0 = 0; mw1 = 0; mm0 = 0; mm1 = 0;
        foreach (q[i]) begin
          mw0 += q[i] * (1 << (4 * i));
          mw1 += q[i] * (1 << (4 * (3 - i)));
          mm0 |= 1 << i;
          mm1 |= 1 << (3 - i);
        end
        mp = (q.size() < 4);
        mv = 1'b1;
        words++;
        q.delete();
        comp = 1'b1;
      end
    end
    if (!comp && mv && r) mv = 1'b0;
    check_outputs("model");
  endtask

  task automatic apply_reset();
    system1000_rstn = 1'b0;
    #1;
    model_clear();
    check_outputs("reset");
    @(posedge system1000);
    #1;
    system1000_rstn = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  n;
    logic        l;
    logic        r;
    logic        ev;
    logic [15:0] w0;
    logic [3:0]  m0;
    logic [15:0] w1;
    logic [3:0]  m1;
    logic        p;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int w_before;
    n_cmp = 0;
    n_fail = 0;
    words = 0;
    in_valid = 1'b0;
    in_nib = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    system1000_rstn = 1'b0;
    model_clear();

    // Directed vectors: full word, partial word, ignored in_last, 1-slot word, MSN order.
    tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000, 4'h0, 1'b0};
    tbl[2]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 16'h0000, 4'h0, 1'b0};
    tbl[3]  = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 16'h4321, 4'hF, 16'h1234, 4'hF, 1'b0};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h4321, 4'hF, 16'h1234, 4'hF, 1'b0};
    tbl[5]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 16'h4321, 4'hF, 16'h1234, 4'hF, 1'b0};
    tbl[6]  = '{1'b1, 4'h6, 1'b1, 1'b1, 1'b1, 16'h0065, 4'h3, 16'h5600, 4'hC, 1'b1};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 16'h0065, 4'h3, 16'h5600, 4'hC, 1'b1};
    tbl[8]  = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 16'h0007, 4'h1, 16'h7000, 4'h8, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0007, 4'h1, 16'h7000, 4'h8, 1'b1};
    tbl[10] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 16'h0007, 4'h1, 16'h7000, 4'h8, 1'b1};
    tbl[11] = '{1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 16'h0007, 4'h1, 16'h7000, 4'h8, 1'b1};
    tbl[12] = '{1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 16'h0007, 4'h1, 16'h7000, 4'h8, 1'b1};
    tbl[13] = '{1'b1, 4'hD, 1'b0, 1'b1, 1'b1, 16'hDCBA, 4'hF, 16'hABCD, 4'hF, 1'b0};

    // Reset state
    #12;
    check_outputs("reset");
    check("reset_in_ready", 32'(in_ready0), 32'd1);
    @(posedge system1000);
    #1;
    system1000_rstn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].v, tbl[i].n, tbl[i].l, tbl[i].r);
      check("tbl_valid",   32'(out_valid0),   32'(tbl[i].ev));
      check("tbl_word0",   32'(out_word0),    32'(tbl[i].w0));
      check("tbl_mask0",   32'(out_mask0),    32'(tbl[i].m0));
      check("tbl_word1",   32'(out_word1),    32'(tbl[i].w1));
      check("tbl_mask1",   32'(out_mask1),    32'(tbl[i].m1));
      check("tbl_partial", 32'(out_partial0), 32'(tbl[i].p));
    end

    // Stall: full word held for 10 cycles while a closing nibble waits.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'h9, 1'b1, 1'b0);
      check("stall_in_ready", 32'(in_ready0), 32'd0);
      check("stall_word", 32'(out_word0), 32'h4321);
      check("stall_valid", 32'(out_valid0), 32'd1);
    end
    step(1'b1, 4'h9, 1'b1, 1'b1);
    check("b2b_valid", 32'(out_valid0), 32'd1);
    check("b2b_word", 32'(out_word0), 32'h0009);
    check("b2b_mask", 32'(out_mask0), 32'h1);
    check("b2b_partial", 32'(out_partial0), 32'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // Continuous random nibbles, consumer always ready.
    w_before = words;
    for (int i = 0; i < 1600; i++) step(1'b1, 4'($urandom), 1'b0, 1'b1);
    check("stream_words", 32'(words - w_before), 32'd400);

    // Random handshake and in_last traffic.
    for (int i = 0; i < 600; i++)
      step(1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));

    // Reset mid-word: partial accumulator discarded.
    step(1'b1, 4'h3, 1'b0, 1'b1);
    step(1'b1, 4'h4, 1'b0, 1'b1);
    apply_reset();
    step(1'b1, 4'h7, 1'b0, 1'b1);
    step(1'b1, 4'h8, 1'b0, 1'b1);
    step(1'b1, 4'h9, 1'b0, 1'b1);
    step(1'b1, 4'hA, 1'b0, 1'b1);
    check("rst_word0", 32'(out_word0), 32'hA987);
    check("rst_word1", 32'(out_word1), 32'h789A);
    check("rst_valid", 32'(out_valid0), 32'd1);

    // Reset mid-stall: pending word dropped, no output afterwards.
    step(1'b1, 4'h1, 1'b1, 1'b0);
    step(1'b1, 4'h2, 1'b1, 1'b0);
    apply_reset();
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("rst_stall_valid", 32'(out_valid0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
